// File: rtl/mux_pipe_if.sv
// rtl/mux_pipe_if.sv - handshake bundle for the pipelined N-way word selector
//
// Groups the upstream side (option, data_in, in_valid, in_ready) and the
// downstream side (out_data, out_err, out_valid, out_ready) of mux_pipe.
//   slave  : the selector's own view (consumes option/data_in, produces out_*)
//   master : the environment's view (drives offers and out_ready)
// WIDTH and N must match the parameters of the mux_pipe instance using it.

interface mux_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [SEL_W-1:0]   option;
    logic [N*WIDTH-1:0] data_in;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  option,
        input  data_in,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_err,
        output out_valid,
        input  out_ready
    );

    modport master (
        output option,
        output data_in,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_err,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - pipelined, back-pressurable N-way word selector
//
// Each accepted offer captures data_in word [option] (or word 0 with err set
// when option >= N) and presents it on out_* one cycle later. A main entry
// drives the outputs; a skid entry absorbs the one extra offer that can
// arrive while in_ready is still high after downstream stalls.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears both entries and outputs
//   bus  - mux_pipe_if.slave: option/data_in/in_valid/in_ready upstream,
//          out_data/out_err/out_valid/out_ready downstream

module mux_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input  logic        clk,
    input  logic        rst,
    mux_pipe_if.slave   bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        st_empty = 2'b00,
        st_one   = 2'b10,
        st_full  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             out_valid_r;
    logic             in_ready_r;

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             accept;
    logic             consume;

    // Decode by comparison against every legal index so an out-of-range
    // option never forms an out-of-bounds slice; when N is a power of two
    // every code matches and sel_err folds to constant 0.
    always_comb begin
        sel_err  = 1'b1;
        sel_word = bus.data_in[WIDTH-1:0];
        for (int i = 0; i < N; i++) begin
            if (bus.option == SEL_W'(i)) begin
                sel_err  = 1'b0;
                sel_word = bus.data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept  = bus.in_valid & in_ready_r;
    assign consume = out_valid_r & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= st_empty;
            main_data   <= '0;
            main_err    <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                st_empty: begin
                    if (accept) begin
                        main_data   <= sel_word;
                        main_err    <= sel_err;
                        out_valid_r <= 1'b1;
                        state       <= st_one;
                    end
                end
                st_one: begin
                    if (accept && consume) begin
                        // Head leaves and the new word replaces it: no bubble.
                        main_data <= sel_word;
                        main_err  <= sel_err;
                    end else if (accept) begin
                        // Downstream stalled; park the new word, stop upstream.
                        skid_data  <= sel_word;
                        skid_err   <= sel_err;
                        in_ready_r <= 1'b0;
                        state      <= st_full;
                    end else if (consume) begin
                        out_valid_r <= 1'b0;
                        state       <= st_empty;
                    end
                end
                st_full: begin
                    // in_ready is low here, so only the consume side can move.
                    if (consume) begin
                        main_data  <= skid_data;
                        main_err   <= skid_err;
                        in_ready_r <= 1'b1;
                        state      <= st_one;
                    end
                end
                default: begin
                    state       <= st_empty;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data  = main_data;
    assign bus.out_err   = main_err;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;
endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - self-checking bench for mux_pipe (N=8/W=32, N=5/W=32, N=3/W=8)

module tb_mux_pipe;
    logic clk;
    logic rst;

    mux_pipe_if #(.WIDTH(32), .N(8)) if_a ();
    mux_pipe_if #(.WIDTH(32), .N(5)) if_b ();
    mux_pipe_if #(.WIDTH(8),  .N(3)) if_c ();

    mux_pipe #(.WIDTH(32), .N(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    mux_pipe #(.WIDTH(32), .N(5)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    mux_pipe #(.WIDTH(8),  .N(3)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [31:0] wa [8];
    logic [31:0] wb [5];
    logic [7:0]  wc [3];

    for (genvar i = 0; i < 8; i++) assign if_a.data_in[i*32 +: 32] = wa[i];
    for (genvar i = 0; i < 5; i++) assign if_b.data_in[i*32 +: 32] = wb[i];
    for (genvar i = 0; i < 3; i++) assign if_c.data_in[i*8 +: 8]   = wc[i];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: two-slot FIFO per DUT ----------------
    function automatic bit in_v(int k);
        case (k)
            0:       return if_a.in_valid;
            1:       return if_b.in_valid;
            default: return if_c.in_valid;
        endcase
    endfunction

    function automatic bit out_r(int k);
        case (k)
            0:       return if_a.out_ready;
            1:       return if_b.out_ready;
            default: return if_c.out_ready;
        endcase
    endfunction

    // {err, word}: the word the offered option names, or word 0 flagged as error
    function automatic logic [32:0] pick(int k);
        int o;
        case (k)
            0: begin
                o = int'(if_a.option);
                return (o < 8) ? {1'b0, wa[o]} : {1'b1, wa[0]};
            end
            1: begin
                o = int'(if_b.option);
                return (o < 5) ? {1'b0, wb[o]} : {1'b1, wb[0]};
            end
            default: begin
                o = int'(if_c.option);
                return (o < 3) ? {1'b0, 24'h0, wc[o]} : {1'b1, 24'h0, wc[0]};
            end
        endcase
    endfunction

    function automatic logic [34:0] obs(int k);
        case (k)
            0:       return {if_a.in_ready, if_a.out_valid, if_a.out_err, if_a.out_data};
            1:       return {if_b.in_ready, if_b.out_valid, if_b.out_err, if_b.out_data};
            default: return {if_c.in_ready, if_c.out_valid, if_c.out_err, 24'h0, if_c.out_data};
        endcase
    endfunction

    logic [32:0] ment [3][2];
    int          mcnt [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        logic [32:0] e0, e1;
        int          c;
        bit          acc, con;
        if (rst) begin
            for (int k = 0; k < 3; k++) mcnt[k] <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                e0  = ment[k][0];
                e1  = ment[k][1];
                c   = mcnt[k];
                acc = in_v(k) && (c < 2);
                con = (c > 0) && out_r(k);
                if (con) begin
                    e0 = e1;
                    c  = c - 1;
                end
                if (acc) begin
                    if (c == 0) e0 = pick(k);
                    else        e1 = pick(k);
                    c = c + 1;
                end
                ment[k][0] <= e0;
                ment[k][1] <= e1;
                mcnt[k]    <= c;
            end
        end
    end

    always @(negedge clk) begin
        logic [34:0] o;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                o = obs(k);
                check($sformatf("dut%0d in_ready", k), 64'(o[34]), 64'(mcnt[k] < 2));
                check($sformatf("dut%0d out_valid", k), 64'(o[33]), 64'(mcnt[k] > 0));
                if (mcnt[k] > 0)
                    check($sformatf("dut%0d err_data", k), 64'(o[32:0]), 64'(ment[k][0]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 8; i++) wa[i] = 32'hA000_0000 + i;
        wb[0] = 32'h1234_5678;
        for (int i = 1; i < 5; i++) wb[i] = 32'hB000_0000 + i;
        for (int i = 0; i < 3; i++) wc[i] = 8'h10 + 8'(i);
        if_a.option = '0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
        if_b.option = '0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        if_c.option = '0; if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;

        tick();
        chk_en = 1;
        check("reset out_valid", 64'(if_a.out_valid), 64'd0);
        check("reset out_data",  64'(if_a.out_data),  64'd0);
        check("reset out_err",   64'(if_a.out_err),   64'd0);
        check("reset in_ready",  64'(if_a.in_ready),  64'd1);
        tick();
        rst = 1'b0;

        // Stream options 0..7 at full rate
        for (int i = 0; i < 8; i++) begin
            if_a.option   = 3'(i);
            if_a.in_valid = 1'b1;
            tick();
            check($sformatf("stream data %0d", i), 64'(if_a.out_data), 64'(32'hA000_0000 + i));
            check($sformatf("stream valid %0d", i), 64'(if_a.out_valid), 64'd1);
        end
        if_a.in_valid = 1'b0;
        tick();
        check("stream drained", 64'(if_a.out_valid), 64'd0);
        tick();

        // Back-pressure: 3, 5, 6 with out_ready low
        if_a.out_ready = 1'b0;
        if_a.in_valid  = 1'b1;
        if_a.option    = 3'd3;
        tick();
        check("bp c1 data", 64'(if_a.out_data), 64'hA000_0003);
        check("bp c1 in_ready", 64'(if_a.in_ready), 64'd1);
        if_a.option = 3'd5;
        tick();
        check("bp c2 data", 64'(if_a.out_data), 64'hA000_0003);
        check("bp c2 in_ready", 64'(if_a.in_ready), 64'd0);
        if_a.option = 3'd6;
        tick();
        tick();
        check("bp held data", 64'(if_a.out_data), 64'hA000_0003);
        check("bp held in_ready", 64'(if_a.in_ready), 64'd0);
        if_a.out_ready = 1'b1;
        tick();
        check("bp out 5", 64'(if_a.out_data), 64'hA000_0005);
        tick();
        if_a.in_valid = 1'b0;
        check("bp out 6", 64'(if_a.out_data), 64'hA000_0006);
        check("bp out 6 valid", 64'(if_a.out_valid), 64'd1);
        tick();
        check("bp empty", 64'(if_a.out_valid), 64'd0);

        // Out-of-range on N=5
        if_b.in_valid = 1'b1;
        if_b.option   = 3'd6;
        tick();
        check("oor data", 64'(if_b.out_data), 64'h1234_5678);
        check("oor err",  64'(if_b.out_err),  64'd1);
        if_b.option = 3'd4;
        tick();
        if_b.in_valid = 1'b0;
        check("inrange err",  64'(if_b.out_err),  64'd0);
        check("inrange data", 64'(if_b.out_data), 64'hB000_0004);
        tick();

        // Asynchronous reset while FULL
        if_a.out_ready = 1'b0;
        if_a.in_valid  = 1'b1;
        if_a.option    = 3'd1;
        tick();
        if_a.option = 3'd2;
        tick();
        if_a.in_valid = 1'b0;
        check("full in_ready", 64'(if_a.in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async out_valid", 64'(if_a.out_valid), 64'd0);
        check("async out_data",  64'(if_a.out_data),  64'd0);
        check("async in_ready",  64'(if_a.in_ready),  64'd1);
        tick();
        rst = 1'b0;
        if_a.out_ready = 1'b1;
        if_a.in_valid  = 1'b1;
        if_a.option    = 3'd7;
        tick();
        if_a.in_valid = 1'b0;
        check("post-reset first", 64'(if_a.out_data), 64'hA000_0007);
        tick();
        check("post-reset only one", 64'(if_a.out_valid), 64'd0);

        // Random traffic on N=3, WIDTH=8, checked every cycle by the model
        for (int n = 0; n < 10000; n++) begin
            if_c.in_valid  = 1'($urandom_range(0, 1));
            if_c.option    = 2'($urandom_range(0, 3));
            if_c.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) wc[i] = 8'($urandom);
            tick();
        end
        if_c.in_valid  = 1'b0;
        if_c.out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("random drained", 64'(if_c.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
